// File: rtl/dmem_lsu_ctrl.sv
// Load/store unit between the execute stage and a word-organised, 1-cycle-latency data RAM.
// Optional macro LSU_BYTE_STROBE_EN: adds mem_be and writes sub-word stores directly, with no read-modify-write.
module dmem_lsu_ctrl #(
  parameter int WORD_AW = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_memop,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [WORD_AW-1:0] mem_addr,
  output logic               mem_re,
  input  logic [31:0]        mem_rdata,
  output logic               mem_we,
`ifdef LSU_BYTE_STROBE_EN
  output logic [3:0]         mem_be,
`endif
  output logic [31:0]        mem_wdata
);

  // state | meaning
  // IDLE  | ready for a request
  // RD    | RAM read issued (load, or first half of SB/SH read-modify-write)
  // WR    | RAM write issued, store completes
  // RSP   | load data returned, extended
  // ERR   | misaligned address or illegal memop, no RAM access
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RSP, S_ERR} state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_we;
  logic [2:0]           r_memop;
  logic [WORD_AW+1:0]   r_addr;
  logic [31:0]          r_wdata;

  logic                 w_accept;
  logic                 w_legal;
  logic                 w_misaligned;
  logic                 w_store_direct;
  logic [4:0]           w_shift;
  logic [31:0]          w_lane;
  logic [31:0]          w_load;
  logic [31:0]          w_store;
  logic                 w_unused_addr;

  assign w_unused_addr = ^req_addr[31:WORD_AW+2];
  assign w_accept      = req_valid && (r_state == S_IDLE);

  always_comb begin
    w_legal = 1'b0;
    case (req_memop)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !req_we;
      default:                w_legal = 1'b0;
    endcase
  end

  assign w_misaligned = ((req_memop[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_memop[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_BYTE_STROBE_EN
  assign w_store_direct = 1'b1;
`else
  assign w_store_direct = (req_memop == 3'b010);
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_memop <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_memop <= req_memop;
        r_addr  <= req_addr[WORD_AW+1:0];
        r_wdata <= req_wdata;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (!w_legal || w_misaligned) w_next = S_ERR;
          else if (req_we && w_store_direct) w_next = S_WR;
          else w_next = S_RD;
        end
      end
      S_RD:    w_next = r_we ? S_WR : S_RSP;
      S_WR:    w_next = S_IDLE;
      S_RSP:   w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_shift = {r_addr[1:0], 3'b000};
  assign w_lane  = mem_rdata >> w_shift;

  always_comb begin
    w_load = w_lane;
    case (r_memop)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load = {24'h0, w_lane[7:0]};
      3'b101:  w_load = {16'h0, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

`ifdef LSU_BYTE_STROBE_EN
  logic [3:0] w_be;

  always_comb begin
    w_store = r_wdata;
    w_be    = 4'hF;
    case (r_memop[1:0])
      2'b00: begin
        w_store = {4{r_wdata[7:0]}};
        w_be    = 4'b0001 << r_addr[1:0];
      end
      2'b01: begin
        w_store = {2{r_wdata[15:0]}};
        w_be    = 4'b0011 << r_addr[1:0];
      end
      default: begin
        w_store = r_wdata;
        w_be    = 4'hF;
      end
    endcase
  end

  assign mem_be = (r_state == S_WR) ? w_be : 4'h0;
`else
  logic [31:0] w_mask;

  // SW has a full mask, so the stale mem_rdata never reaches the RAM.
  always_comb begin
    case (r_memop[1:0])
      2'b00:   w_mask = 32'h0000_00FF << w_shift;
      2'b01:   w_mask = 32'h0000_FFFF << w_shift;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign w_store = (mem_rdata & ~w_mask) | ((r_wdata << w_shift) & w_mask);
`endif

  assign mem_addr = r_addr[WORD_AW+1:2];

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_RD:   mem_re = 1'b1;
      S_WR: begin
        mem_we     = 1'b1;
        mem_wdata  = w_store;
        resp_valid = 1'b1;
      end
      S_RSP: begin
        resp_valid = 1'b1;
        resp_rdata = w_load;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl (default build): vector table plus scoreboard queues,
// with hand-written back-to-back, mid-op reset and address-wrap sequences.
module tb_dmem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_memop = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;
  logic        mem_we;
  logic [31:0] mem_wdata;

  dmem_lsu_ctrl #(.WORD_AW(10)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:1023];

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
    ram[0] <= 32'h8081_7F01;
    ram[1] <= 32'h1122_3344;
  end

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nwe;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  exp_t sb_q[$];
  rsp_t rsp_q[$];
  int   cyc = 0;
  int   we_cnt = 0;
  int   resp_cnt = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
    if (resp_valid === 1'b1) begin
      resp_cnt <= resp_cnt + 1;
      rsp_q.push_back('{resp_rdata, resp_err, cyc});
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic we, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] wd, input logic err,
                              input logic [31:0] rd, input int lat, input int nwe);
    vec_t v;
    v.name = n; v.we = we; v.op = op; v.addr = a; v.wdata = wd;
    v.err = err; v.rdata = rd; v.lat = lat; v.nwe = nwe;
    return v;
  endfunction

  // Drive one request at a negedge once ready, push its expectation, return one negedge later.
  task automatic start_op(input vec_t v);
    int k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (req_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL %s_ready_timeout: got req_ready=%b, expected 1", v.name, req_ready);
    end
    req_valid = 1'b1; req_we = v.we; req_memop = v.op;
    req_addr = v.addr; req_wdata = v.wdata;
    sb_q.push_back('{v.name, v.rdata, v.err, v.lat, cyc});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    exp_t e;
    rsp_t r;
    while (sb_q.size() > 0) begin
      int k = 0;
      while (rsp_q.size() == 0 && k < budget) begin
        @(negedge clk);
        k++;
      end
      e = sb_q.pop_front();
      if (rsp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL %s_resp_timeout: got no resp_valid, expected one within %0d cycles", e.name, budget);
        sb_q.delete();
      end else begin
        r = rsp_q.pop_front();
        chk({e.name, "_rdata"}, r.rdata, e.rdata);
        chk({e.name, "_err"}, {31'h0, r.err}, {31'h0, e.err});
        chk({e.name, "_lat"}, r.cyc - e.acc, e.lat);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int w0 = we_cnt;
    start_op(v);
    drain(10);
    @(negedge clk);
    chk({v.name, "_mem_we_count"}, we_cnt - w0, v.nwe);
  endtask

  vec_t vecs [0:22];
  vec_t b2b  [0:2];

  initial begin
    int w0;
    int r0;
    vec_t v;

    vecs[0]  = mk("lb_a1",        0, 3'b000, 32'h0000_0001, 32'h0,         0, 32'h0000_007F, 2, 0);
    vecs[1]  = mk("lb_a3",        0, 3'b000, 32'h0000_0003, 32'h0,         0, 32'hFFFF_FF80, 2, 0);
    vecs[2]  = mk("lbu_a3",       0, 3'b100, 32'h0000_0003, 32'h0,         0, 32'h0000_0080, 2, 0);
    vecs[3]  = mk("lh_a2",        0, 3'b001, 32'h0000_0002, 32'h0,         0, 32'hFFFF_8081, 2, 0);
    vecs[4]  = mk("lhu_a2",       0, 3'b101, 32'h0000_0002, 32'h0,         0, 32'h0000_8081, 2, 0);
    vecs[5]  = mk("lw_a0",        0, 3'b010, 32'h0000_0000, 32'h0,         0, 32'h8081_7F01, 2, 0);
    vecs[6]  = mk("lh_a0",        0, 3'b001, 32'h0000_0000, 32'h0,         0, 32'h0000_7F01, 2, 0);
    vecs[7]  = mk("lb_a0",        0, 3'b000, 32'h0000_0000, 32'h0,         0, 32'h0000_0001, 2, 0);
    vecs[8]  = mk("sb_a5",        1, 3'b000, 32'h0000_0005, 32'hFFFF_FFAA, 0, 32'h0,         2, 1);
    vecs[9]  = mk("lw_a4_sb",     0, 3'b010, 32'h0000_0004, 32'h0,         0, 32'h1122_AA44, 2, 0);
    vecs[10] = mk("sh_a6",        1, 3'b001, 32'h0000_0006, 32'h1234_BEEF, 0, 32'h0,         2, 1);
    vecs[11] = mk("lw_a4_sh",     0, 3'b010, 32'h0000_0004, 32'h0,         0, 32'hBEEF_AA44, 2, 0);
    vecs[12] = mk("sw_a8",        1, 3'b010, 32'h0000_0008, 32'h1234_5678, 0, 32'h0,         1, 1);
    vecs[13] = mk("lw_wrap_1008", 0, 3'b010, 32'h0000_1008, 32'h0,         0, 32'h1234_5678, 2, 0);
    vecs[14] = mk("err_lw_a2",    0, 3'b010, 32'h0000_0002, 32'h0,         1, 32'h0,         1, 0);
    vecs[15] = mk("err_sh_a1",    1, 3'b001, 32'h0000_0001, 32'h0000_FFFF, 1, 32'h0,         1, 0);
    vecs[16] = mk("err_st_op100", 1, 3'b100, 32'h0000_0004, 32'h0000_00AA, 1, 32'h0,         1, 0);
    vecs[17] = mk("err_ld_op011", 0, 3'b011, 32'h0000_0000, 32'h0,         1, 32'h0,         1, 0);
    vecs[18] = mk("err_lhu_a3",   0, 3'b101, 32'h0000_0003, 32'h0,         1, 32'h0,         1, 0);
    vecs[19] = mk("err_st_op101", 1, 3'b101, 32'h0000_0004, 32'h0000_1234, 1, 32'h0,         1, 0);
    vecs[20] = mk("err_ld_op110", 0, 3'b110, 32'h0000_0000, 32'h0,         1, 32'h0,         1, 0);
    vecs[21] = mk("err_st_op111", 1, 3'b111, 32'h0000_0004, 32'h0000_00FF, 1, 32'h0,         1, 0);
    vecs[22] = mk("lw_a4_noerr",  0, 3'b010, 32'h0000_0004, 32'h0,         0, 32'hBEEF_AA44, 2, 0);

    b2b[0] = mk("b2b_lw_a0",  0, 3'b010, 32'h0000_0000, 32'h0,         0, 32'h8081_7F01, 2, 0);
    b2b[1] = mk("b2b_sw_a12", 1, 3'b010, 32'h0000_000C, 32'hCAFE_F00D, 0, 32'h0,         1, 1);
    b2b[2] = mk("b2b_lb_a12", 0, 3'b000, 32'h0000_000C, 32'h0,         0, 32'h0000_000D, 2, 0);

    repeat (3) @(negedge clk);
    chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
    chk("rst_mem_re",     {31'h0, mem_re},     32'h0);
    chk("rst_mem_we",     {31'h0, mem_we},     32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr",   {22'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata",  mem_wdata,  32'h0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 23; i++) run_vec(vecs[i]);

    // Back-to-back with req_valid held high throughout.
    w0 = we_cnt;
    r0 = resp_cnt;
    for (int i = 0; i < 3; i++) begin
      int k = 0;
      if (i > 0) chk($sformatf("b2b_ready_low_%0d", i), {31'h0, req_ready}, 32'h0);
      req_valid = 1'b1; req_we = b2b[i].we; req_memop = b2b[i].op;
      req_addr = b2b[i].addr; req_wdata = b2b[i].wdata;
      while (req_ready !== 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      sb_q.push_back('{b2b[i].name, b2b[i].rdata, b2b[i].err, b2b[i].lat, cyc});
      @(negedge clk);
    end
    req_valid = 1'b0;
    drain(10);
    repeat (2) @(negedge clk);
    chk("b2b_resp_count", resp_cnt - r0, 3);
    chk("b2b_we_count",   we_cnt - w0,   1);

    // SB abandoned by reset during its RD cycle.
    w0 = we_cnt;
    r0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_memop = 3'b000;
    req_addr = 32'h0000_0004; req_wdata = 32'h0000_0077;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_in_rd_mem_re", {31'h0, mem_re}, 32'h1);
    rstn = 1'b0;
    @(negedge clk);
    chk("rstmid_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rstmid_mem_we",    {31'h0, mem_we},    32'h0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_no_write", we_cnt - w0,   0);
    chk("rstmid_no_resp",  resp_cnt - r0, 0);
    chk("rstmid_ready",    {31'h0, req_ready}, 32'h1);

    // Word address wraps modulo RAM size; target of the abandoned SB still unchanged.
    v = mk("lw_wrap_1004", 0, 3'b010, 32'h0000_1004, 32'h0, 0, 32'hBEEF_AA44, 2, 0);
    start_op(v);
    chk("wrap_mem_addr", {22'h0, mem_addr}, 32'h1);
    chk("wrap_mem_re",   {31'h0, mem_re},   32'h1);
    drain(10);

    repeat (3) @(negedge clk);
    chk("stray_resp", rsp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
